// File: rtl/seg_scan_ctrl_if.sv
// seg_scan_ctrl_if: connects the timer/counter datapath and the LED pin side
// to the 7-segment scan controller.
//   data       hex nibbles, nibble i drives digit i (digit 0 = least significant)
//   dig_mask   1 = digit i may light
//   dp         1 = decimal point of digit i lit
//   lz_en      1 = leading-zero suppression on
//   led_en     active-low digit enables (at most one bit low)
//   led_seg    active-low segments, bit7 = dp, bits6:0 = g..a
//   frame_tick one-cycle pulse when a new frame is captured
// master = datapath/pin side, slave = scan controller.
interface seg_scan_ctrl_if #(
  parameter int unsigned N_DIG = 8
);
  logic [4*N_DIG-1:0] data;
  logic [N_DIG-1:0]   dig_mask;
  logic [N_DIG-1:0]   dp;
  logic               lz_en;
  logic [N_DIG-1:0]   led_en;
  logic [7:0]         led_seg;
  logic               frame_tick;

  modport master (
    output data, dig_mask, dp, lz_en,
    input  led_en, led_seg, frame_tick
  );

  modport slave (
    input  data, dig_mask, dp, lz_en,
    output led_en, led_seg, frame_tick
  );
endinterface

// File: rtl/seg_scan_ctrl.sv
// seg_scan_ctrl: time-multiplexed scan controller for a common-anode
// 7-segment bank. Inputs are captured once per frame so a frame never mixes
// old and new digits; each digit slot starts with a blanking interval to
// suppress ghosting. All outputs are registered (one cycle behind cnt/idx).
// Ports:
//   clk  system clock
//   rst  synchronous, active-high reset
//   bus  seg_scan_ctrl_if slave modport (data/mask/dp/lz_en in, LED out)
module seg_scan_ctrl #(
  parameter int unsigned N_DIG     = 8,
  parameter int unsigned SCAN_DIV  = 100000,
  parameter int unsigned BLANK_CYC = 1000
) (
  input  logic           clk,
  input  logic           rst,
  seg_scan_ctrl_if.slave bus
);

  localparam int unsigned CNT_W = $clog2(SCAN_DIV);
  localparam int unsigned IDX_W = (N_DIG > 2) ? $clog2(N_DIG) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SCAN_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_SHOW = CNT_W'(BLANK_CYC);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_DIG - 1);

  typedef enum logic {
    PH_BLANK,
    PH_SHOW
  } phase_t;

  logic [CNT_W-1:0]   cnt;
  logic [IDX_W-1:0]   idx;

  // Frame registers
  logic [4*N_DIG-1:0] f_data;
  logic [N_DIG-1:0]   f_mask;
  logic [N_DIG-1:0]   f_dp;
  logic [N_DIG-1:0]   f_supp;

  phase_t             phase;
  logic               frame_end;
  logic [N_DIG-1:0]   supp_nxt;
  logic [3:0]         cur_nib;
  logic               cur_vis;
  logic [N_DIG-1:0]   en_nxt;
  logic [7:0]         seg_nxt;

  function automatic logic [6:0] hex7(input logic [3:0] n);
    case (n)
      4'h0: hex7 = 7'h3F;  4'h1: hex7 = 7'h06;
      4'h2: hex7 = 7'h5B;  4'h3: hex7 = 7'h4F;
      4'h4: hex7 = 7'h66;  4'h5: hex7 = 7'h6D;
      4'h6: hex7 = 7'h7D;  4'h7: hex7 = 7'h07;
      4'h8: hex7 = 7'h7F;  4'h9: hex7 = 7'h6F;
      4'hA: hex7 = 7'h77;  4'hB: hex7 = 7'h7C;
      4'hC: hex7 = 7'h39;  4'hD: hex7 = 7'h5E;
      4'hE: hex7 = 7'h79;  default: hex7 = 7'h71;
    endcase
  endfunction

  always_comb begin
    logic any_nz;
    phase     = (cnt < CNT_SHOW) ? PH_BLANK : PH_SHOW;
    frame_end = (cnt == CNT_LAST) && (idx == IDX_LAST);

    // Walk from the most significant digit down; a digit is suppressed
    // until the first non-zero nibble at or above it is seen. Digit 0 never is.
    any_nz   = 1'b0;
    supp_nxt = '0;
    for (int unsigned k = 0; k < N_DIG; k++) begin
      any_nz = any_nz | (|bus.data[4*(N_DIG-1-k) +: 4]);
      supp_nxt[N_DIG-1-k] = bus.lz_en & ~any_nz & (k != N_DIG - 1);
    end

    cur_nib = f_data[{idx, 2'b00} +: 4];
    cur_vis = f_mask[idx] & ~f_supp[idx];

    en_nxt  = '1;
    seg_nxt = '1;
    if (phase == PH_SHOW && cur_vis) begin
      en_nxt[idx] = 1'b0;
      seg_nxt     = {~f_dp[idx], ~hex7(cur_nib)};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt            <= '0;
      idx            <= '0;
      f_data         <= '0;
      f_mask         <= '0;
      f_dp           <= '0;
      f_supp         <= '0;
      bus.led_en     <= '1;
      bus.led_seg    <= '1;
      bus.frame_tick <= 1'b0;
    end else begin
      bus.frame_tick <= frame_end;
      bus.led_en     <= en_nxt;
      bus.led_seg    <= seg_nxt;
      if (cnt == CNT_LAST) begin
        cnt <= '0;
        if (idx == IDX_LAST) begin
          idx    <= '0;
          f_data <= bus.data;
          f_mask <= bus.dig_mask;
          f_dp   <= bus.dp;
          f_supp <= supp_nxt;
        end else begin
          idx <= idx + 1'b1;
        end
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Testbench for seg_scan_ctrl (N_DIG=4, SCAN_DIV=8, BLANK_CYC=2).
// A cycle model keyed on the count of non-reset edges pushes the expected
// outputs after every rising edge; they are popped and compared on the
// following falling edge.
module tb_seg_scan_ctrl;

  localparam int unsigned N_DIG     = 4;
  localparam int unsigned SCAN_DIV  = 8;
  localparam int unsigned BLANK_CYC = 2;
  localparam int unsigned FRAME     = N_DIG * SCAN_DIV;

  logic clk = 1'b0;
  logic rst;

  seg_scan_ctrl_if #(.N_DIG(N_DIG)) bus ();

  seg_scan_ctrl #(
    .N_DIG    (N_DIG),
    .SCAN_DIV (SCAN_DIV),
    .BLANK_CYC(BLANK_CYC)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  // Segment patterns (active-high g..a) for 0..F.
  logic [6:0] seg_tab [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                               7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

  // Model frame state and scoreboard
  logic [15:0] m_data;
  logic [3:0]  m_mask, m_dp;
  logic        m_lz;
  int unsigned t;
  logic [12:0] sb [$];   // {tick, led_en[3:0], led_seg[7:0]}

  always @(posedge clk) begin
    int unsigned p, s, c;
    int hi;
    logic [3:0] en;
    logic [7:0] seg;
    logic vis;
    if (rst) begin
      sb.push_back({1'b0, 4'hF, 8'hFF});
      m_data = '0; m_mask = '0; m_dp = '0; m_lz = 1'b0;
      t = 0;
    end else begin
      p = t % FRAME;
      s = p / SCAN_DIV;
      c = p % SCAN_DIV;
      hi = -1;
      for (int j = 0; j < int'(N_DIG); j++)
        if (m_data[4*j +: 4] != 4'h0) hi = j;
      vis = m_mask[s] && !(m_lz && s != 0 && int'(s) > hi);
      en  = 4'hF;
      seg = 8'hFF;
      if (c >= BLANK_CYC && vis) begin
        en[s] = 1'b0;
        seg = {~m_dp[s], ~seg_tab[m_data[4*s +: 4]]};
      end
      sb.push_back({(p == FRAME - 1), en, seg});
      if (p == FRAME - 1) begin
        m_data = bus.data; m_mask = bus.dig_mask; m_dp = bus.dp; m_lz = bus.lz_en;
      end
      t++;
    end
  end

  always @(negedge clk) begin
    logic [12:0] e;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk("led_en", 32'(bus.led_en), 32'(e[11:8]));
      chk("led_seg", 32'(bus.led_seg), 32'(e[7:0]));
      chk("frame_tick", 32'(bus.frame_tick), 32'(e[12]));
      chk("one_digit", 32'($countones(~bus.led_en) <= 1), 32'd1);
    end
  end

  // Waits (on falling edges) for frame_tick; returns the cycles it took.
  task automatic wait_tick(input string tag, output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (bus.frame_tick !== 1'b1 && n < 3 * FRAME);
    if (bus.frame_tick !== 1'b1) chk({tag, "_timeout"}, 32'(n), 32'(FRAME));
  endtask

  task automatic set_in(input logic [15:0] d, input logic [3:0] m,
                        input logic [3:0] p, input logic lz);
    bus.data = d; bus.dig_mask = m; bus.dp = p; bus.lz_en = lz;
  endtask

  initial begin
    int n;
    rst = 1'b1;
    set_in(16'h0000, 4'h0, 4'h0, 1'b0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    // 1: dark first frame, first tick 32 cycles after release
    wait_tick("first_tick", n);
    chk("first_tick_lat", 32'(n), 32'(FRAME));
    wait_tick("tick_period", n);
    chk("tick_period", 32'(n), 32'(FRAME));

    // 2: basic scan
    set_in(16'h1234, 4'hF, 4'h0, 1'b0);
    wait_tick("basic", n);
    repeat (FRAME - 1) @(negedge clk);

    // 3: leading zeros
    set_in(16'h0050, 4'hF, 4'h0, 1'b1);
    wait_tick("lz1", n);
    set_in(16'h0000, 4'hF, 4'h0, 1'b1);
    wait_tick("lz2", n);
    set_in(16'h0050, 4'hF, 4'h0, 1'b0);
    wait_tick("lz3", n);

    // 4: mask and decimal point
    set_in(16'hABCD, 4'b0101, 4'b0001, 1'b0);
    wait_tick("mask", n);

    // 5: anti-tearing
    set_in(16'h1111, 4'hF, 4'h0, 1'b0);
    wait_tick("tear_a", n);
    wait_tick("tear_b", n);
    repeat (2 * SCAN_DIV + 3) @(negedge clk);
    bus.data = 16'h2222;
    wait_tick("tear_c", n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (bus.led_seg !== 8'hA4 && n < 2 * FRAME);
    chk("tear_first_a4", 32'(n), 32'd3);

    // 6: reset during SHOW of digit 1
    wait_tick("mid_rst", n);
    repeat (SCAN_DIV + 4) @(negedge clk);
    chk("pre_rst_lit", 32'(bus.led_en), 32'(4'b1101));
    rst = 1'b1;
    @(negedge clk);
    chk("rst_en", 32'(bus.led_en), 32'hF);
    chk("rst_seg", 32'(bus.led_seg), 32'hFF);
    rst = 1'b0;
    wait_tick("post_rst", n);
    chk("post_rst_lat", 32'(n), 32'(FRAME));
    repeat (FRAME + 2) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad + 1);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/seg_scan_ctrl.md
# seg_scan_ctrl

Time-multiplexed scan controller for the board's common-anode 7-segment display bank. It takes a packed hex value from the counting/timer datapath and captures it once per frame, so a frame never mixes old and new digits. It then drives one digit at a time with active-low digit enables and active-low segments, with a dead-time blanking interval between digits to suppress ghosting. Optional leading-zero suppression is supported. It sits between the timer/counter datapath and the top-level LED pins.

## Interface
- N_DIG, 8, number of digits scanned (2..8)
- SCAN_DIV, 100000, clock cycles per digit slot (1 ms at 100 MHz); must be > BLANK_CYC
- BLANK_CYC, 1000, cycles at the start of each slot with all digits dark; must be >= 1

- clk  in  1  system clock; single clock domain
- rst  in  1  synchronous, active-high reset
- data  in  4*N_DIG  hex nibbles; nibble i = data[4i+3:4i] drives digit i (digit 0 = least significant)
- dig_mask  in  N_DIG  1 = digit i may light
- dp  in  N_DIG  1 = decimal point of digit i lit
- lz_en  in  1  1 = leading-zero suppression on
- led_en  out  N_DIG  active-low digit enables; at most one bit low at any time
- led_seg  out  8  active-low segments; bit7 = dp, bits6:0 = g,f,e,d,c,b,a
- frame_tick  out  1  one-cycle pulse when a new frame is captured

## Operation
- Slot counter cnt runs 0..SCAN_DIV-1. Digit index idx runs 0..N_DIG-1 and advances when cnt = SCAN_DIV-1.
- When cnt = SCAN_DIV-1 and idx = N_DIG-1, the controller starts a new frame:
  - idx returns to 0.
  - data, dig_mask, dp and lz_en are latched into frame registers.
  - frame_tick is asserted for the next cycle.
- Inputs are sampled only at frame capture. Changes at any other time have no effect until the next frame.
- Each slot runs two phases, decided from the current cnt:
  - BLANK (cnt < BLANK_CYC): led_en = all 1, led_seg = 8'hFF.
  - SHOW (cnt >= BLANK_CYC): digit idx is driven if it is visible.
- Visibility of digit i in the captured frame:
  - The digit must have dig_mask[i] = 1.
  - The digit must not be suppressed. Digit i is suppressed when lz_en = 1, i != 0, and all captured nibbles j >= i are 0.
  - Digit 0 is never suppressed.
  - Compute the suppression vector at capture time and register it with the frame.
- Driving a visible digit in SHOW: led_en has only bit idx low. led_seg[6:0] = ~decode(nibble idx). led_seg[7] = ~dp[idx].
- If the digit is not visible, SHOW behaves exactly like BLANK.
- Hex decode (active-high g..a, inverted at the output):
  - 0 = 3F, 1 = 06, 2 = 5B, 3 = 4F, 4 = 66, 5 = 6D, 6 = 7D, 7 = 07
  - 8 = 7F, 9 = 6F, A = 77, b = 7C, C = 39, d = 5E, E = 79, F = 71
- Counter widths: cnt is $clog2(SCAN_DIV) bits, idx is $clog2(N_DIG) bits (minimum 1). There is no wrap other than the explicit compares above.

## Timing
- All outputs are registered. led_en and led_seg reflect the (idx, cnt, frame registers) of the previous cycle, so each output change lags its phase boundary by exactly 1 cycle.
- Frame period: N_DIG*SCAN_DIV cycles. Lit time per digit: SCAN_DIV-BLANK_CYC cycles.
- Reset (rst high at a clk edge) clears, on that edge:
  - cnt and idx to 0
  - all frame registers to 0 (so mask = 0 and the display is dark)
  - led_en to all 1, led_seg to 8'hFF, frame_tick to 0
- Reset asserted mid-slot or mid-frame takes effect on the next edge, with no partial digit afterwards.
- After reset release:
  - The first frame is dark.
  - The first capture occurs N_DIG*SCAN_DIV cycles after the first non-reset edge, with frame_tick high in the following cycle.
  - Captured data is first visible BLANK_CYC+1 cycles after that capture edge.
- frame_tick is never asserted for more than 1 consecutive cycle. It is never asserted while rst is high.
- led_en never has two bits low, including across idx transitions. This is guaranteed because BLANK_CYC >= 1.

## Test plan
Bench parameters: N_DIG=4, SCAN_DIV=8, BLANK_CYC=2.
1. Reset: hold rst for 3 cycles, then release. Required: led_en = 4'hF, led_seg = 8'hFF and frame_tick = 0 throughout the first 32 cycles; frame_tick pulses exactly once at cycle 32 and then every 32 cycles.
2. Basic scan: data = 16'h1234, dig_mask = 4'hF, lz_en = 0, dp = 0. In the second frame, slot 0 shows 2 dark cycles, then led_en = 4'b1110 with led_seg = 8'h99 for 6 cycles. Slots 1/2/3 show led_en = 1101/1011/0111 with led_seg = 8'hB0/A4/F9.
3. Leading zeros: data = 16'h0050, lz_en = 1. Required: digits 3 and 2 stay dark; digit 1 shows 8'h92; digit 0 shows 8'hC0. With data = 0, only digit 0 lights, showing 8'hC0. With lz_en = 0, all four digits show 8'hC0 / 8'h92 as appropriate.
4. Mask and decimal point: dig_mask = 4'b0101, dp = 4'b0001, data = 16'hABCD. Required: digit 0 shows 8'h21 (d with dp), digit 2 shows 8'h83, and digits 1 and 3 stay dark.
5. Anti-tearing: change data from 16'h1111 to 16'h2222 during slot 2. Required: the remainder of the frame shows 8'hF9; 8'hA4 first appears in slot 0 of the next frame, 3 cycles after frame_tick.
6. Mid-operation reset: assert rst during SHOW of digit 1. Required: on the next cycle led_en = 4'hF and led_seg = 8'hFF; the following 32 cycles are dark; scanning restarts at digit 0.
